// File: rtl/vfu_wb_arbiter_pkg.sv
// Shared types for the vector write-back arbiter: instruction ids, element data and arbitration mode.
// Optional feature macro used by this slice: VFU_WB_BYPASS_EN (0-cycle FIFO bypass in vfu_wb_arbiter).
package vfu_wb_arbiter_pkg;

    localparam int unsigned NrVInsn = 8;
    localparam int unsigned ELEN    = 64;

    typedef logic [$clog2(NrVInsn)-1:0] vid_t;
    typedef logic [ELEN-1:0]            elen_t;

    typedef enum logic {
        WbArbFixed = 1'b0,
        WbArbRR    = 1'b1
    } wb_arb_mode_e;

endpackage

// File: rtl/vfu_wb_fifo.sv
// Single-channel write-back FIFO with per-slot valid/id exported for pending-instruction tracking.
// Not affected by VFU_WB_BYPASS_EN; bypassed entries simply never get pushed here.
module vfu_wb_fifo
    import vfu_wb_arbiter_pkg::*;
#(
    parameter int unsigned Depth     = 2,
    parameter type         payload_t = logic
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  vid_t                  id_i,
    input  payload_t              payload_i,
    output logic                  full_o,
    output logic                  empty_o,
    output vid_t                  head_id_o,
    output payload_t              head_payload_o,
    output logic [Depth-1:0]      valid_o,
    output vid_t [Depth-1:0]      ids_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    typedef logic [PtrW-1:0] ptr_t;

    ptr_t             rd_ptr_q, wr_ptr_q;
    logic [Depth-1:0] valid_q;
    vid_t [Depth-1:0] id_q;
    payload_t         mem_q [Depth];

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    // Entries stay contiguous, so one valid bit per slot gives full/empty directly.
    assign full_o         = valid_q[wr_ptr_q];
    assign empty_o        = !valid_q[rd_ptr_q];
    assign head_id_o      = id_q[rd_ptr_q];
    assign head_payload_o = mem_q[rd_ptr_q];
    assign valid_o        = valid_q;
    assign ids_o          = id_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else if (flush_i) begin
            valid_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            if (pop_i) begin
                valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q          <= ptr_inc(rd_ptr_q);
            end
            if (push_i) begin
                valid_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q          <= ptr_inc(wr_ptr_q);
            end
        end
    end

    // NOTE: storage is not reset; valid_q masks stale contents, so only control state needs reset.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            id_q[wr_ptr_q]  <= id_i;
            mem_q[wr_ptr_q] <= payload_i;
        end
    end

endmodule

// File: rtl/vfu_wb_arbiter.sv
// Per-lane write-back arbiter: NrFUs buffered result channels merged onto one VRF write port.
// Define VFU_WB_BYPASS_EN to let live requests reach the VRF port in the same cycle when all FIFOs are idle.
module vfu_wb_arbiter
    import vfu_wb_arbiter_pkg::*;
#(
    parameter int unsigned NrFUs      = 2,
    parameter int unsigned BufDepth   = 2,
    parameter bit          RoundRobin = 1'b1,
    parameter type         vaddr_t    = logic,
    parameter int unsigned DataWidth  = $bits(elen_t),
    parameter type         strb_t     = logic [DataWidth/8-1:0]
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NrFUs-1:0]          fu_req_i,
    input  vid_t [NrFUs-1:0]          fu_id_i,
    input  vaddr_t [NrFUs-1:0]        fu_addr_i,
    input  elen_t [NrFUs-1:0]         fu_wdata_i,
    input  strb_t [NrFUs-1:0]         fu_be_i,
    output logic [NrFUs-1:0]          fu_gnt_o,
    output logic                      vrf_req_o,
    output vid_t                      vrf_id_o,
    output vaddr_t                    vrf_addr_o,
    output elen_t                     vrf_wdata_o,
    output strb_t                     vrf_be_o,
    input  logic                      vrf_gnt_i,
    output logic [NrVInsn-1:0]        pending_vinsn_o,
    input  logic                      flush_i
);

    localparam int unsigned IdxW = (NrFUs > 1) ? $clog2(NrFUs) : 1;
    typedef logic [IdxW-1:0] idx_t;

    typedef struct packed {
        vaddr_t addr;
        elen_t  wdata;
        strb_t  be;
    } payload_t;

    localparam wb_arb_mode_e Mode = RoundRobin ? WbArbRR : WbArbFixed;

    logic [NrFUs-1:0]                 full, empty, push, pop;
    vid_t [NrFUs-1:0]                 head_id;
    payload_t [NrFUs-1:0]             head_pl, in_pl;
    logic [NrFUs-1:0][BufDepth-1:0]   ent_valid;
    vid_t [NrFUs-1:0][BufDepth-1:0]   ent_id;

    idx_t rr_q, lock_idx_q, sel, start;
    logic lock_q, any_buf, byp, fire;

    // First set bit of cand at or after start, wrapping modulo NrFUs.
    function automatic idx_t pick(input logic [NrFUs-1:0] cand, input idx_t first);
        idx_t res;
        idx_t c;
        logic found;
        res   = '0;
        c     = first;
        found = 1'b0;
        for (int unsigned k = 0; k < NrFUs; k++) begin
            if (!found && cand[c]) begin
                found = 1'b1;
                res   = c;
            end
            c = (c == idx_t'(NrFUs - 1)) ? '0 : c + 1'b1;
        end
        return res;
    endfunction

    for (genvar i = 0; i < NrFUs; i++) begin : g_fifo
        assign in_pl[i] = '{addr: fu_addr_i[i], wdata: fu_wdata_i[i], be: fu_be_i[i]};

        vfu_wb_fifo #(
            .Depth     (BufDepth),
            .payload_t (payload_t)
        ) i_fifo (
            .clk_i          (clk_i),
            .rst_ni         (rst_ni),
            .flush_i        (flush_i),
            .push_i         (push[i]),
            .pop_i          (pop[i]),
            .id_i           (fu_id_i[i]),
            .payload_i      (in_pl[i]),
            .full_o         (full[i]),
            .empty_o        (empty[i]),
            .head_id_o      (head_id[i]),
            .head_payload_o (head_pl[i]),
            .valid_o        (ent_valid[i]),
            .ids_o          (ent_id[i])
        );
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        any_buf = |(~empty);
        start   = (Mode == WbArbRR) ? rr_q : '0;
        sel     = lock_q ? lock_idx_q : pick(~empty, start);
        byp     = 1'b0;
`ifdef VFU_WB_BYPASS_EN
        if (!any_buf && !lock_q && !flush_i && (|fu_req_i)) begin
            byp = 1'b1;
            sel = pick(fu_req_i, start);
        end
`endif
        vrf_req_o   = any_buf | byp;
        vrf_id_o    = byp ? fu_id_i[sel]    : head_id[sel];
        vrf_addr_o  = byp ? fu_addr_i[sel]  : head_pl[sel].addr;
        vrf_wdata_o = byp ? fu_wdata_i[sel] : head_pl[sel].wdata;
        vrf_be_o    = byp ? fu_be_i[sel]    : head_pl[sel].be;
        fire        = vrf_req_o & vrf_gnt_i;

        for (int i = 0; i < NrFUs; i++) begin
            fu_gnt_o[i] = fu_req_i[i] & ~full[i] & ~flush_i;
            // A granted bypass goes straight to the VRF and must not also land in the FIFO.
            push[i]     = fu_gnt_o[i] & ~(byp & fire & (sel == idx_t'(i)));
            pop[i]      = any_buf & fire & (sel == idx_t'(i));
        end
    end

    always_comb begin
        pending_vinsn_o = '0;
        for (int i = 0; i < NrFUs; i++) begin
            for (int j = 0; j < BufDepth; j++) begin
                if (ent_valid[i][j]) pending_vinsn_o[ent_id[i][j]] = 1'b1;
            end
        end
    end

    // The lock pins the presented channel until the VRF takes it, keeping vrf_* stable.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else if (flush_i) begin
            lock_q <= 1'b0;
        end else if (fire) begin
            lock_q <= 1'b0;
            rr_q   <= (sel == idx_t'(NrFUs - 1)) ? '0 : sel + 1'b1;
        end else if (vrf_req_o) begin
            lock_q     <= 1'b1;
            lock_idx_q <= sel;
        end
    end

endmodule

// File: tb/tb_vfu_wb_arbiter.sv
// Self-checking bench: round-robin and fixed-priority instances share stimulus and are checked against a queue model.
// Bypass expectations follow VFU_WB_BYPASS_EN when the bundle is built with it.
module tb_vfu_wb_arbiter;
    import vfu_wb_arbiter_pkg::*;

    localparam int unsigned NrFUs    = 2;
    localparam int unsigned BufDepth = 2;

    typedef logic [7:0] addr_t;
    typedef logic [7:0] be_t;
    typedef struct packed {
        vid_t  id;
        addr_t addr;
        elen_t data;
        be_t   be;
    } ent_t;

    logic clk = 1'b0;
    logic rst_ni;
    always #5 clk = ~clk;

    logic [NrFUs-1:0]  fu_req;
    vid_t [NrFUs-1:0]  fu_id;
    addr_t [NrFUs-1:0] fu_addr;
    elen_t [NrFUs-1:0] fu_wdata;
    be_t [NrFUs-1:0]   fu_be;
    logic              vrf_gnt, flush;

    logic [NrFUs-1:0]   fu_gnt [2];
    logic               vrf_req [2];
    vid_t               vrf_id [2];
    addr_t              vrf_addr [2];
    elen_t              vrf_wdata [2];
    be_t                vrf_be [2];
    logic [NrVInsn-1:0] pending [2];

    vfu_wb_arbiter #(.NrFUs(NrFUs), .BufDepth(BufDepth), .RoundRobin(1'b1), .vaddr_t(addr_t)) dut_rr (
        .clk_i(clk), .rst_ni(rst_ni), .fu_req_i(fu_req), .fu_id_i(fu_id), .fu_addr_i(fu_addr),
        .fu_wdata_i(fu_wdata), .fu_be_i(fu_be), .fu_gnt_o(fu_gnt[0]), .vrf_req_o(vrf_req[0]),
        .vrf_id_o(vrf_id[0]), .vrf_addr_o(vrf_addr[0]), .vrf_wdata_o(vrf_wdata[0]), .vrf_be_o(vrf_be[0]),
        .vrf_gnt_i(vrf_gnt), .pending_vinsn_o(pending[0]), .flush_i(flush)
    );

    vfu_wb_arbiter #(.NrFUs(NrFUs), .BufDepth(BufDepth), .RoundRobin(1'b0), .vaddr_t(addr_t)) dut_fixed (
        .clk_i(clk), .rst_ni(rst_ni), .fu_req_i(fu_req), .fu_id_i(fu_id), .fu_addr_i(fu_addr),
        .fu_wdata_i(fu_wdata), .fu_be_i(fu_be), .fu_gnt_o(fu_gnt[1]), .vrf_req_o(vrf_req[1]),
        .vrf_id_o(vrf_id[1]), .vrf_addr_o(vrf_addr[1]), .vrf_wdata_o(vrf_wdata[1]), .vrf_be_o(vrf_be[1]),
        .vrf_gnt_i(vrf_gnt), .pending_vinsn_o(pending[1]), .flush_i(flush)
    );

    // Reference model: index 0 = round-robin instance, 1 = fixed-priority instance.
    ent_t               q [2][NrFUs][$];
    bit                 lock_m [2];
    int                 lock_ch [2];
    int                 rr_m [2];
    bit                 e_req [2];
    bit                 e_byp [2];
    int                 e_sel [2];
    logic [NrFUs-1:0]   e_gnt [2];
    logic [NrVInsn-1:0] e_pend [2];
    ent_t               e_head [2];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int first_from(input logic [NrFUs-1:0] cand, input int first);
        for (int k = 0; k < NrFUs; k++) begin
            int c;
            c = (first + k) % NrFUs;
            if (cand[c]) return c;
        end
        return 0;
    endfunction

    function automatic ent_t live(input int ch);
        ent_t e;
        e.id   = fu_id[ch];
        e.addr = fu_addr[ch];
        e.data = fu_wdata[ch];
        e.be   = fu_be[ch];
        return e;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < NrFUs; i++) q[m][i].delete();
            lock_m[m]  = 0;
            lock_ch[m] = 0;
            rr_m[m]    = 0;
        end
    endtask

    task automatic model_eval(input int m);
        logic [NrFUs-1:0]   nonempty;
        logic [NrVInsn-1:0] pend;
        int                 first;
        nonempty = '0;
        pend     = '0;
        for (int i = 0; i < NrFUs; i++) begin
            nonempty[i] = (q[m][i].size() != 0);
            foreach (q[m][i][j]) pend[q[m][i][j].id] = 1'b1;
            e_gnt[m][i] = fu_req[i] && (q[m][i].size() < BufDepth) && !flush;
        end
        first    = (m == 0) ? rr_m[m] : 0;
        e_byp[m] = 0;
        e_sel[m] = 0;
        if (lock_m[m]) e_sel[m] = lock_ch[m];
        else if (nonempty != '0) e_sel[m] = first_from(nonempty, first);
`ifdef VFU_WB_BYPASS_EN
        else if (!flush && fu_req != '0) begin
            e_byp[m] = 1;
            e_sel[m] = first_from(fu_req, first);
        end
`endif
        e_req[m]  = (nonempty != '0) || e_byp[m];
        e_pend[m] = pend;
        if (e_byp[m]) e_head[m] = live(e_sel[m]);
        else if (nonempty != '0) e_head[m] = q[m][e_sel[m]][0];
    endtask

    task automatic model_commit(input int m);
        bit fire;
        fire = e_req[m] && vrf_gnt;
        if (flush) begin
            for (int i = 0; i < NrFUs; i++) q[m][i].delete();
            lock_m[m] = 0;
        end else begin
            if (fire) begin
                if (!e_byp[m]) void'(q[m][e_sel[m]].pop_front());
                lock_m[m] = 0;
                rr_m[m]   = (e_sel[m] + 1) % NrFUs;
            end else if (e_req[m]) begin
                lock_m[m]  = 1;
                lock_ch[m] = e_sel[m];
            end
            for (int i = 0; i < NrFUs; i++) begin
                if (e_gnt[m][i] && !(e_byp[m] && fire && e_sel[m] == i)) q[m][i].push_back(live(i));
            end
        end
    endtask

    task automatic check_outputs(input int m);
        string nm;
        nm = (m == 0) ? "rr" : "fixed";
        check({nm, ".vrf_req"}, 64'(vrf_req[m]), 64'(e_req[m]));
        check({nm, ".fu_gnt"},  64'(fu_gnt[m]),  64'(e_gnt[m]));
        check({nm, ".pending"}, 64'(pending[m]), 64'(e_pend[m]));
        if (e_req[m]) begin
            check({nm, ".vrf_id"},    64'(vrf_id[m]),   64'(e_head[m].id));
            check({nm, ".vrf_addr"},  64'(vrf_addr[m]), 64'(e_head[m].addr));
            check({nm, ".vrf_wdata"}, vrf_wdata[m],     e_head[m].data);
            check({nm, ".vrf_be"},    64'(vrf_be[m]),   64'(e_head[m].be));
        end
    endtask

    // One clock: inputs are already applied; sample on negedge, advance the model on posedge.
    task automatic cycle();
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            model_eval(m);
            check_outputs(m);
        end
        @(posedge clk);
        if (rst_ni) begin
            for (int m = 0; m < 2; m++) model_commit(m);
        end
        #1;
    endtask

    task automatic clear_inputs();
        fu_req   = '0;
        fu_id    = '0;
        fu_addr  = '0;
        fu_wdata = '0;
        fu_be    = '0;
        flush    = 1'b0;
    endtask

    task automatic drive(input int ch, input vid_t id, input addr_t addr, input elen_t data);
        fu_req[ch]   = 1'b1;
        fu_id[ch]    = id;
        fu_addr[ch]  = addr;
        fu_wdata[ch] = data;
        fu_be[ch]    = 8'hFF;
    endtask

    initial begin
        rst_ni  = 1'b0;
        vrf_gnt = 1'b0;
        clear_inputs();
        model_reset();

        // Reset state, including the combinational accept path while reset is held.
        cycle();
        fu_req = '1;
        cycle();
        clear_inputs();
        rst_ni = 1'b1;

        // Single write with the VRF always ready.
        vrf_gnt = 1'b1;
        drive(0, 3'd1, 8'h10, 64'hA);
        cycle();
        clear_inputs();
        repeat (3) cycle();

        // Back-to-back pushes against a stalled VRF, then drain.
        vrf_gnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(0, vid_t'(k), 8'h20 + addr_t'(k), 64'h100 + elen_t'(k));
            drive(1, vid_t'(k + 4), 8'h30 + addr_t'(k), 64'h200 + elen_t'(k));
            cycle();
        end
        clear_inputs();
        vrf_gnt = 1'b1;
        repeat (7) cycle();

        // Lock: ch1 presented and stalled while ch0 arrives.
        vrf_gnt = 1'b0;
        drive(1, 3'd5, 8'h55, 64'h5555);
        cycle();
        clear_inputs();
        cycle();
        drive(0, 3'd6, 8'h66, 64'h6666);
        cycle();
        clear_inputs();
        repeat (2) cycle();
        vrf_gnt = 1'b1;
        repeat (3) cycle();

        // Flush with full FIFOs and a simultaneous new request.
        vrf_gnt = 1'b0;
        repeat (2) begin
            drive(0, 3'd2, 8'h02, 64'h22);
            drive(1, 3'd3, 8'h03, 64'h33);
            cycle();
        end
        drive(0, 3'd7, 8'h77, 64'h77);
        flush = 1'b1;
        cycle();
        clear_inputs();
        repeat (2) cycle();

        // Asynchronous reset mid-stream with full FIFOs.
        repeat (2) begin
            drive(0, 3'd2, 8'h12, 64'h1212);
            drive(1, 3'd3, 8'h13, 64'h1313);
            cycle();
        end
        clear_inputs();
        #2 rst_ni = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            check("async_rst.vrf_req", 64'(vrf_req[m]), 64'd0);
            check("async_rst.pending", 64'(pending[m]), 64'd0);
        end
        model_reset();
        cycle();
        rst_ni  = 1'b1;
        vrf_gnt = 1'b1;
        drive(1, 3'd7, 8'h70, 64'h7070);
        cycle();
        clear_inputs();
        repeat (2) cycle();

        // Idle FIFOs with the VRF ready: bypass when enabled, 1-cycle latency otherwise.
        drive(1, 3'd4, 8'h44, 64'h4444);
        cycle();
        clear_inputs();
        repeat (2) cycle();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NrFUs; i++) begin
                fu_req[i]   = ($urandom_range(0, 2) != 0);
                fu_id[i]    = vid_t'($urandom);
                fu_addr[i]  = addr_t'($urandom);
                fu_wdata[i] = {$urandom, $urandom};
                fu_be[i]    = be_t'($urandom);
            end
            vrf_gnt = ($urandom_range(0, 2) != 0);
            flush   = ($urandom_range(0, 40) == 0);
            cycle();
        end
        clear_inputs();
        vrf_gnt = 1'b1;
        repeat (6) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
